uart_rx_os16: RTL and testbench

- UART receiver for 8N1 frames (one start bit, eight data bits, one stop bit).
- Consumes the 16x oversampling enable from the baud-rate generator and deserialises the asynchronous `rx` line.
- Presents each completed byte with a sticky ready flag until software or a consumer clears it.
- Sits between the FPGA pin (through an internal synchronizer) and the downstream byte consumer.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync.sv | 27 ++
 rtl/uart_rx_os16.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Parity reception is built in when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_e;

  localparam int DATA_BITS_DEF   = 8;
  localparam int OVERSAMPLE_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic int sample_w(input int os);
    return $clog2(os);
  endfunction

  function automatic int bit_w(input int db);
    return $clog2(db + 1);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Reset-to-one flop chain for asynchronous inputs (rx, later CTS).
// Idle-high lines read as idle straight out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '1;
    end else begin
      q_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        q_q[i] <= q_q[i-1];
      end
    end
  end

  assign q_o = q_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver on a 16x oversample enable, sticky rdy/ferr/overrun.
// Define UART_RX_PARITY_EN for 8E1 frames with a perr output.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 ferr,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 perr
`endif
);

  localparam int SW = sample_w(OVERSAMPLE);
  localparam int BW = bit_w(DATA_BITS);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  state_e               state_q, state_d;
  logic [SW-1:0]        sample_q, sample_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdy_q, rdy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_50m),
    .rst_ni(rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = perr_q;
`endif
    // Clear first so a same-cycle completion still raises rdy.
    if (rdy_clr) rdy_d = 1'b0;
    if (rxclk_en) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d  = START;
            sample_d = '0;
          end
        end
        START: begin
          if (rx_s) begin
            state_d = IDLE;
          end else if (sample_q == S_MID) begin
            sample_d = '0;
            bit_d    = '0;
            state_d  = DATA;
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
        DATA: begin
          if (sample_q == S_LAST) begin
            shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
            sample_d = '0;
            bit_d    = bit_q + 1'b1;
            if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_q == S_LAST) begin
            par_d    = rx_s;
            sample_d = '0;
            state_d  = STOP;
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
`endif
        STOP: begin
          if (sample_q == S_LAST) begin
            sample_d = '0;
            if (rx_s) begin
              data_d  = shift_q;
              rdy_d   = 1'b1;
              ferr_d  = 1'b0;
              ovr_d   = ovr_q | rdy_q;
`ifdef UART_RX_PARITY_EN
              perr_d  = (^shift_q) ^ par_q;
`endif
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (rdy_clr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sample_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      rdy_q    <= rdy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign data    = data_q;
  assign rdy     = rdy_q;
  assign ferr    = ferr_q;
  assign overrun = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign perr    = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: enable every 25 clocks, 16 ticks/bit.
// Parity vectors are included when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os16;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rxclk_en = 1'b0;
  logic       rx      = 1'b1;
  logic       rdy_clr = 1'b0;
  logic [7:0] data;
  logic       rdy;
  logic       ferr;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       perr;
  localparam int LAT = 168;
`else
  localparam int LAT = 152;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int div_cnt  = 0;
  int tick_cnt = 0;
  int rise_tick = 0;
  int fall_tick = 0;
  int lat;
  logic rdy_prev = 1'b0;

  uart_rx_os16 dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .rxclk_en(rxclk_en),
    .rx      (rx),
    .rdy_clr (rdy_clr),
    .data    (data),
    .rdy     (rdy),
    .ferr    (ferr),
    .overrun (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .perr    (perr)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  // Enable generator plus tick counter and rdy-rise timestamp.
  always @(negedge clk_50m) begin
    if (rxclk_en) tick_cnt = tick_cnt + 1;
    div_cnt  = (div_cnt == 24) ? 0 : div_cnt + 1;
    rxclk_en = (div_cnt == 0);
    if (rdy && !rdy_prev) rise_tick = tick_cnt;
    rdy_prev = rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50m);
      while (!rxclk_en) @(posedge clk_50m);
    end
    #1;
  endtask

  task automatic send_head(input logic [7:0] b, input logic par);
    rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    ticks(16);
`else
    if (par) rx = 1'b0;
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic par);
    send_head(b, par);
    rx = stop;
    ticks(16);
  endtask

  task automatic send_good(input logic [7:0] b);
`ifdef UART_RX_PARITY_EN
    send_frame(b, 1'b1, ^b);
`else
    send_frame(b, 1'b1, 1'b0);
`endif
  endtask

  task automatic pulse_clr();
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
  endtask

  initial begin
    repeat (5) @(negedge clk_50m);
    check("rst_data", data, 0);
    check("rst_rdy", rdy, 0);
    check("rst_ferr", ferr, 0);
    check("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    ticks(4);

    fall_tick = tick_cnt;
    send_good(8'hA5);
    @(negedge clk_50m);
    lat = rise_tick - fall_tick - 1;
    check("a5_data", data, 8'hA5);
    check("a5_rdy", rdy, 1);
    check("a5_ferr", ferr, 0);
    check("a5_latency", (lat >= LAT - 2 && lat <= LAT + 2), 1);
    pulse_clr();
    check("clr_rdy", rdy, 0);

    ticks(3);
    rx = 1'b0;
    ticks(5);
    rx = 1'b1;
    ticks(20);
    @(negedge clk_50m);
    check("glitch_rdy", rdy, 0);
    send_good(8'h3C);
    @(negedge clk_50m);
    check("3c_data", data, 8'h3C);
    check("3c_rdy", rdy, 1);
    pulse_clr();

    ticks(3);
    send_frame(8'h55, 1'b0, ^8'h55);
    ticks(40);
    @(negedge clk_50m);
    check("fe_ferr", ferr, 1);
    check("fe_rdy", rdy, 0);
    check("fe_data", data, 8'h3C);
    rx = 1'b1;
    ticks(170);
    @(negedge clk_50m);
    check("brk_rdy", rdy, 0);
    check("brk_data", data, 8'h3C);
    send_good(8'h0F);
    @(negedge clk_50m);
    check("0f_data", data, 8'h0F);
    check("0f_ferr", ferr, 0);
    check("0f_rdy", rdy, 1);
    pulse_clr();

    ticks(3);
    send_good(8'h11);
    @(negedge clk_50m);
    check("11_rdy", rdy, 1);
    check("11_ovr", overrun, 0);
    ticks(3);
    send_good(8'h22);
    @(negedge clk_50m);
    check("22_data", data, 8'h22);
    check("22_ovr", overrun, 1);

    ticks(3);
    send_head(8'h33, ^8'h33);
    rx = 1'b1;
    ticks(8);
    repeat (24) @(posedge clk_50m);
    @(negedge clk_50m);
    rdy_clr = 1'b1;
    @(negedge clk_50m);
    rdy_clr = 1'b0;
    check("col_rdy", rdy, 1);
    check("col_ovr", overrun, 0);
    check("col_data", data, 8'h33);
    ticks(7);

    ticks(3);
    rx = 1'b0;
    ticks(16);
    rx = 1'b1;
    ticks(64 + 8);
    rst_n = 1'b0;
    #1;
    check("mrst_data", data, 0);
    check("mrst_rdy", rdy, 0);
    check("mrst_ferr", ferr, 0);
    check("mrst_ovr", overrun, 0);
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    ticks(20);
    send_good(8'h81);
    @(negedge clk_50m);
    check("81_data", data, 8'h81);
    check("81_rdy", rdy, 1);
    pulse_clr();

`ifdef UART_RX_PARITY_EN
    ticks(3);
    send_frame(8'h07, 1'b1, 1'b1);
    @(negedge clk_50m);
    check("p1_data", data, 8'h07);
    check("p1_perr", perr, 0);
    pulse_clr();
    ticks(3);
    send_frame(8'h07, 1'b1, 1'b0);
    @(negedge clk_50m);
    check("p0_perr", perr, 1);
    check("p0_rdy", rdy, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
